// File: rtl/sw_feed_sequencer.sv
// Smith-Waterman feed sequencer: serialises 512-bit cache lines into the systolic
// array's byte stream (query phase, then target phase), then collects the array result.
module sw_feed_sequencer #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] query_len,
    input  logic [CNT_W-1:0] target_len,
    input  logic [511:0]     line_data,
    input  logic             line_valid,
    output logic             line_ready,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             conf_out,
    output logic [CNT_W-1:0] count_out,
    input  logic [511:0]     array_data,
    input  logic             array_valid,
    output logic [511:0]     result_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LINE_BYTES = CNT_W'(64);

    typedef enum logic [2:0] {StIdle, StLoadQ, StStreamT, StDrain, StResult} state_e;

    state_e           state_q, state_d;
    logic             busy_q;
    logic [CNT_W-1:0] qlen_q, qlen_d, tlen_q, tlen_d;
    logic [CNT_W-1:0] rem_q, rem_d;      // phase bytes not yet emitted
    logic [CNT_W-1:0] unbuf_q, unbuf_d;  // phase bytes not yet pulled into the buffer
    logic [511:0]     line_q, line_d;
    logic [5:0]       idx_q, idx_d;
    logic [6:0]       bcnt_q, bcnt_d;    // bytes still to emit from the buffered line
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [511:0]     res_q, res_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             zpend_q, zpend_d;  // zero-length start: done follows one cycle later
    logic [6:0]       take;
    logic             in_phase, emit;

    // State register and registered busy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            qlen_q  <= '0;
            tlen_q  <= '0;
            rem_q   <= '0;
            unbuf_q <= '0;
            line_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            dcnt_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            zpend_q <= 1'b0;
        end else begin
            qlen_q  <= qlen_d;
            tlen_q  <= tlen_d;
            rem_q   <= rem_d;
            unbuf_q <= unbuf_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            dcnt_q  <= dcnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
            zpend_q <= zpend_d;
        end
    end

    // Next-state: phase sequencing, line buffer, drain timer, result capture
    always_comb begin
        state_d = state_q;
        qlen_d  = qlen_q;
        tlen_d  = tlen_q;
        rem_d   = rem_q;
        unbuf_d = unbuf_q;
        line_d  = line_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        dcnt_d  = dcnt_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = zpend_q;
        zpend_d = 1'b0;
        take    = (unbuf_q >= LINE_BYTES) ? 7'd64 : unbuf_q[6:0];
        if (abort) begin
            state_d = StIdle;
            bcnt_d  = '0;
            idx_d   = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        qlen_d = query_len;
                        tlen_d = target_len;
                        err_d  = 1'b0;
                        if (query_len == '0 || target_len == '0) begin
                            err_d   = 1'b1;
                            zpend_d = 1'b1;
                        end else begin
                            state_d = StLoadQ;
                            rem_d   = query_len;
                            unbuf_d = query_len;
                            bcnt_d  = '0;
                            idx_d   = '0;
                        end
                    end
                end
                StLoadQ, StStreamT: begin
                    if (bcnt_q != '0) begin
                        idx_d  = idx_q + 6'd1;
                        bcnt_d = bcnt_q - 7'd1;
                        rem_d  = rem_q - CNT_W'(1);
                    end
                    if (line_valid && line_ready) begin
                        line_d  = line_data;
                        idx_d   = '0;
                        bcnt_d  = take;
                        unbuf_d = unbuf_q - {{(CNT_W - 7){1'b0}}, take};
                    end
                    // Last phase byte: drop any tail of the line, next phase starts fresh
                    if (bcnt_q != '0 && rem_q == CNT_W'(1)) begin
                        bcnt_d = '0;
                        idx_d  = '0;
                        if (state_q == StLoadQ) begin
                            state_d = StStreamT;
                            rem_d   = tlen_q;
                            unbuf_d = tlen_q;
                        end else begin
                            state_d = StDrain;
                            dcnt_d  = '0;
                        end
                    end
                end
                StDrain: begin
                    if (array_valid) begin
                        res_d   = array_data;
                        state_d = StResult;
                    end else if (dcnt_q == DRAIN_LAST) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                StResult: begin
                    if (result_ready) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        in_phase     = (state_q == StLoadQ) || (state_q == StStreamT);
        emit         = in_phase && (bcnt_q != '0);
        line_ready   = in_phase && (unbuf_q != '0) && (bcnt_q == 7'd0 || bcnt_q == 7'd1);
        valid_out    = emit;
        data_out     = emit ? line_q[{idx_q, 3'b000} +: 8] : 8'd0;
        conf_out     = (state_q == StLoadQ);
        count_out    = (state_q == StLoadQ) ? qlen_q :
                       (state_q == StStreamT) ? tlen_q : '0;
        result_valid = (state_q == StResult);
        result_data  = res_q;
        busy         = busy_q;
        done         = done_q;
        error        = err_q;
    end

endmodule

// File: tb/tb_sw_feed_sequencer.sv
// Scoreboard bench for sw_feed_sequencer: expected bytes are queued at job start and
// popped as the DUT streams them.
module tb_sw_feed_sequencer;

    localparam int unsigned CW = 32;
    localparam int unsigned TO = 200;

    logic          clk = 1'b0;
    logic          reset_n, start, abort;
    logic [CW-1:0] query_len, target_len;
    logic [511:0]  line_data;
    logic          line_valid, line_ready;
    logic [7:0]    data_out;
    logic          valid_out, conf_out;
    logic [CW-1:0] count_out;
    logic [511:0]  array_data;
    logic          array_valid;
    logic [511:0]  result_data;
    logic          result_valid, result_ready;
    logic          busy, done, error;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int salt = 0;
    int lines_acc = 0;
    logic feed_en = 1'b0;
    int q_first = -1, q_last = -1, t_first = -1, t_last = -1;
    logic [CW+8:0] exp_q[$];

    sw_feed_sequencer #(.CNT_W(CW), .DRAIN_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .query_len(query_len), .target_len(target_len),
        .line_data(line_data), .line_valid(line_valid), .line_ready(line_ready),
        .data_out(data_out), .valid_out(valid_out), .conf_out(conf_out),
        .count_out(count_out), .array_data(array_data), .array_valid(array_valid),
        .result_data(result_data), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [511:0] got,
                             input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] make_line(input int n);
        logic [511:0] l;
        for (int j = 0; j < 64; j++) l[j*8 +: 8] = 8'(j + 1 + salt * n);
        return l;
    endfunction

    // Line source: offers line N of the current job, N = lines accepted so far
    initial begin
        logic acc, new_job;
        line_valid = 1'b0;
        line_data  = '0;
        forever begin
            @(negedge clk);
            acc     = line_valid && line_ready;
            new_job = start && !busy;
            @(posedge clk);
            #1;
            if (new_job) lines_acc = 0;
            else if (acc) lines_acc++;
            line_data  = make_line(lines_acc);
            line_valid = feed_en;
        end
    end

    // Output monitor: every emitted byte must match the head of the scoreboard
    initial begin
        logic [CW+8:0] item;
        forever begin
            @(negedge clk);
            if (start && !busy) begin
                q_first = -1; q_last = -1; t_first = -1; t_last = -1;
            end
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_size", 512'(exp_q.size()), 512'd1);
                end else begin
                    item = exp_q.pop_front();
                    check_val("byte", 512'({count_out, conf_out, data_out}), 512'(item));
                end
                if (conf_out) begin
                    if (q_first < 0) q_first = cyc;
                    q_last = cyc;
                end else begin
                    if (t_first < 0) t_first = cyc;
                    t_last = cyc;
                end
            end
        end
    end

    task automatic start_job(input int q, input int t, input int s);
        int nq;
        @(posedge clk);
        #1;
        query_len  = CW'(q);
        target_len = CW'(t);
        salt       = s;
        nq         = (q + 63) / 64;
        if (q != 0 && t != 0) begin
            for (int i = 0; i < q; i++)
                exp_q.push_back({CW'(q), 1'b1, 8'((i % 64) + 1 + s * (i / 64))});
            for (int i = 0; i < t; i++)
                exp_q.push_back({CW'(t), 1'b0, 8'((i % 64) + 1 + s * (nq + i / 64))});
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns at the last streamed byte's cycle (just after its negedge)
    task automatic wait_drain(output int last_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val("stream_complete", 512'(exp_q.size()), 512'd0);
        last_cyc = cyc;
    endtask

    task automatic finish_job(input logic [511:0] res, input int exp_lines);
        logic got;
        check_val("lines_accepted", 512'(lines_acc), 512'(exp_lines));
        @(posedge clk);
        #1;
        array_data   = res;
        array_valid  = 1'b1;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        array_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (result_valid) check_val("result_data", result_data, res);
            if (done) begin
                got = 1'b1;
                check_val("done_error", 512'(error), 512'd0);
            end
            @(posedge clk);
            #1;
        end
        check_val("done_seen", 512'(got), 512'd1);
        result_ready = 1'b0;
        @(negedge clk);
        check_val("done_pulse_end", 512'(done), 512'd0);
        check_val("idle_busy", 512'(busy), 512'd0);
    endtask

    initial begin
        int last, n, done_cyc;
        logic [511:0] res;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        query_len = '0; target_len = '0;
        array_data = '0; array_valid = 1'b0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_val("rst_busy", 512'(busy), 512'd0);
        check_val("rst_outs", 512'({done, error, line_ready, valid_out, conf_out, result_valid}),
                  512'd0);
        check_val("rst_data", 512'({data_out, count_out}), 512'd0);
        check_val("rst_result", result_data, 512'd0);
        feed_en = 1'b1;

        // Job 1: q3 t5, result stalled 4 cycles
        start_job(3, 5, 0);
        @(negedge clk);
        check_val("j1_start", 512'({busy, line_ready, conf_out, count_out}),
                  512'({1'b1, 1'b1, 1'b1, CW'(3)}));
        wait_drain(last);
        @(posedge clk);
        #1;
        res = {64{8'hAB}};
        array_data  = res;
        array_valid = 1'b1;
        @(posedge clk);
        #1;
        array_valid = 1'b0;
        array_data  = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("j1_stall", 512'({result_valid, done}), 512'(2'b10));
            check_val("j1_result", result_data, res);
            @(posedge clk);
            #1;
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        @(negedge clk);
        check_val("j1_done", 512'({done, result_valid, busy}), 512'(3'b100));
        @(posedge clk);
        @(negedge clk);
        check_val("j1_done_once", 512'(done), 512'd0);

        // Job 2: q64 t128, gapless streaming over line boundaries
        start_job(64, 128, 3);
        wait_drain(last);
        check_val("j2_q_span", 512'(q_last - q_first), 512'd63);
        check_val("j2_t_span", 512'(t_last - t_first), 512'd127);
        check_val("j2_switch_gap", 512'(t_first - q_last >= 2), 512'd1);
        finish_job({16{32'h1234_5678}}, 3);

        // Job 3: q65, tail of second line discarded, target on third line
        start_job(65, 10, 5);
        wait_drain(last);
        finish_job({8{64'hDEAD_BEEF_0000_0001}}, 3);

        // Zero target length: error, done at t+2, never busy
        start_job(7, 0, 1);
        @(negedge clk);
        check_val("z_t1", 512'({error, done, busy, line_ready}), 512'(4'b1000));
        @(posedge clk);
        @(negedge clk);
        check_val("z_t2", 512'({error, done, busy, line_ready}), 512'(4'b1100));
        @(posedge clk);
        @(negedge clk);
        check_val("z_t3", 512'({done, busy, line_ready}), 512'd0);

        // Drain timeout
        start_job(2, 2, 2);
        wait_drain(last);
        done_cyc = -1;
        for (int k = 0; k < int'(TO) + 20 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (done) done_cyc = cyc;
        end
        check_val("to_cycle", 512'(done_cyc - last - 1), 512'(TO));
        check_val("to_error", 512'(error), 512'd1);
        @(posedge clk);
        @(negedge clk);
        check_val("to_sticky", 512'({error, done, busy}), 512'(3'b100));

        // Abort at 10th target byte; the good start first clears error
        start_job(4, 40, 7);
        @(negedge clk);
        check_val("err_cleared", 512'(error), 512'd0);
        n = 0;
        for (int k = 0; k < 500 && n < 10; k++) begin
            if (valid_out && !conf_out) n++;
            if (n < 10) @(negedge clk);
        end
        check_val("ab_reached", 512'(n), 512'd10);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("ab_idle", 512'({valid_out, line_ready, busy, done, error}), 512'd0);
        end

        // Clean job after abort
        start_job(5, 3, 9);
        wait_drain(last);
        finish_job({32{16'hC0DE}}, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
